time_keeper: RTL and testbench
==============================

// Module: time_keeper
// PURPOSE
//  Running 12-hour time-of-day counter; produces the AMPM/HOUR/MINHIGH/MINLOW
//  fields consumed by the alarm comparator (CompareTime, inputs *1 or *2).
//  Advances on a 1 Hz SEC_TICK strobe in RUN mode. Supports user setting of
//  hour and minute in SET mode. Sits between the prescaler and display/alarm.
// PARAMETERS
//  SECS_PER_MIN  60  SEC_TICK pulses per minute increment (sim may use 2..60)
// PORTS
//  CLK       in   1  system clock, all state on rising edge
//  RST_N     in   1  asynchronous, active-low reset
//  SEC_TICK  in   1  one-CLK-wide 1 Hz strobe from prescaler
//  SET_MODE  in   1  level: 1 = SET mode, 0 = RUN mode (synchronous sample)
//  SET_HOUR  in   1  one-CLK pulse: advance hour by 1 (SET mode only)
//  SET_MIN   in   1  one-CLK pulse: advance minute by 1 (SET mode only)
//  AMPM      out  1  0 = AM, 1 = PM
//  HOUR      out  4  binary hour 1..12
//  MINHIGH   out  3  minute tens digit 0..5
//  MINLOW    out  4  minute units digit 0..9 (BCD)
//  SEC       out  6  seconds count 0..SECS_PER_MIN-1
//  MIN_TICK  out  1  one-CLK pulse when minute fields change (RUN or SET)
// BEHAVIOUR
//  Reset (RST_N=0, async): AMPM=0, HOUR=12, MINHIGH=0, MINLOW=0, SEC=0,
//   MIN_TICK=0, state=RUN. All outputs registered; update 1 CLK after cause.
//  FSM states: RUN, SET.
//   RUN -> SET when SET_MODE=1 sampled; on entry SEC cleared to 0.
//   SET -> RUN when SET_MODE=0 sampled; SEC restarts from 0.
//  RUN: each SEC_TICK increments SEC. When SEC=SECS_PER_MIN-1 and SEC_TICK:
//   SEC->0, minute increments, MIN_TICK=1 next cycle. SET_HOUR/SET_MIN ignored.
//  Minute increment: MINLOW 9->0 carries to MINHIGH; MINHIGH 5 & MINLOW 9 ->
//   00 and (RUN only) carries one hour increment in the same cycle.
//  Hour increment: 12->1; 11->12 toggles AMPM; otherwise HOUR+1.
//   So 11:59 AM -> 12:00 PM, 12:59 PM -> 1:00 PM, 11:59 PM -> 12:00 AM.
//  SET: SEC_TICK ignored, SEC held 0. SET_MIN advances minute with wrap
//   59->00 and NO hour carry. SET_HOUR advances hour (incl. 11->12 AMPM toggle).
//   SET_HOUR and SET_MIN in same cycle: both applied independently.
//   MIN_TICK pulses on SET_MIN only.
//  SET_MODE change and SEC_TICK in same cycle: state transition wins; tick
//   dropped.
//  SET_HOUR/SET_MIN in the cycle SET_MODE first reads 1: ignored (still RUN).
//  Out-of-range values never produced; no illegal-state recovery beyond reset.
//  Reset mid-operation: immediate return to reset values, regardless of state.
// STRUCTURE
//  clock_pkg (include file): localparams ST_RUN/ST_SET, HOUR_MAX=12,
//   MINHIGH_MAX=5, MINLOW_MAX=9, field widths 1/4/3/4.
//  Sub-module mod_counter #(WIDTH, MIN, MAX): ports CLK, RST_N, INC, Q,
//   WRAP. Wraps MAX->MIN on INC and pulses WRAP combinationally. Used for
//   SEC, MINLOW, and MINHIGH. Hour/AMPM logic stays inline because of the
//   12->1 and 11->12 special cases.
//  FSM and carry chain in the top level.
// TESTING (SECS_PER_MIN=4 for speed)
//  1. Reset -> 12:00 AM, SEC=0, MIN_TICK=0. Then release, 4 SEC_TICKs ->
//     12:01 AM, one MIN_TICK pulse.
//  2. Preload 11:59 AM via SET, RUN, 4 ticks -> 12:00 PM (AMPM=1, HOUR=12,
//     MINHIGH=0, MINLOW=0).
//  3. From 12:59 PM: 4 ticks -> 1:00 PM. From 11:59 PM: 4 ticks ->
//     12:00 AM (AMPM=0).
//  4. SET mode at 3:59 AM: SET_MIN -> 3:00 AM (no hour carry). SET_HOUR and
//     SET_MIN together at 11:00 AM -> 12:01 PM. SEC_TICKs change nothing.
//  5. RUN with SEC=2: raise SET_MODE coincident with SEC_TICK -> state SET,
//     SEC=0, tick dropped. Then drop SET_MODE, 4 ticks -> minute +1.
//  6. Async RST_N low mid-second at 7:42 PM (between CLK edges) -> outputs
//     return to 12:00 AM without a CLK edge.
//  Check: outputs match reference model every cycle. Values fed into
//   CompareTime against an alarm of 12:01 AM raise SAME in scenario 1.

Source files
------------

// File: rtl/time_keeper_pkg.sv
// Shared types, field widths and the hour-roll helper for the time-of-day counter.
package time_keeper_pkg;

  localparam int AMPM_W    = 1;
  localparam int HOUR_W    = 4;
  localparam int MINHIGH_W = 3;
  localparam int MINLOW_W  = 4;
  localparam int SEC_W     = 6;

  localparam int HOUR_MAX    = 12;
  localparam int MINHIGH_MAX = 5;
  localparam int MINLOW_MAX  = 9;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } tk_state_t;

  typedef struct packed {
    logic              ampm;
    logic [HOUR_W-1:0] hour;
  } hour_state_t;

  // 12 rolls to 1 without touching AM/PM; 11 rolls to 12 and flips AM/PM.
  function automatic hour_state_t next_hour(input hour_state_t cur);
    hour_state_t nxt;
    nxt = cur;
    if (cur.hour == HOUR_W'(HOUR_MAX)) begin
      nxt.hour = HOUR_W'(1);
    end else if (cur.hour == HOUR_W'(HOUR_MAX - 1)) begin
      nxt.hour = HOUR_W'(HOUR_MAX);
      nxt.ampm = ~cur.ampm;
    end else begin
      nxt.hour = cur.hour + HOUR_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/time_keeper_mod_counter.sv
// Modulo counter MIN..MAX with synchronous clear; WRAP flags the MAX->MIN step.
module time_keeper_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MIN   = 0,
  parameter int MAX   = 9
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             INC,
  output logic [WIDTH-1:0] Q,
  output logic             WRAP
);

  // A clear takes priority, so a clear cycle never reports a wrap.
  assign WRAP = INC && !CLR && (Q == WIDTH'(MAX));

  // Count register: clear beats increment, increment wraps at MAX.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q <= WIDTH'(MIN);
    end else if (CLR) begin
      Q <= WIDTH'(MIN);
    end else if (INC) begin
      if (WRAP) begin
        Q <= WIDTH'(MIN);
      end else begin
        Q <= Q + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/time_keeper.sv
// 12-hour time-of-day counter with RUN/SET modes, driven by a 1 Hz strobe.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int SECS_PER_MIN = 60
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 SEC_TICK,
  input  logic                 SET_MODE,
  input  logic                 SET_HOUR,
  input  logic                 SET_MIN,
  output logic                 AMPM,
  output logic [HOUR_W-1:0]    HOUR,
  output logic [MINHIGH_W-1:0] MINHIGH,
  output logic [MINLOW_W-1:0]  MINLOW,
  output logic [SEC_W-1:0]     SEC,
  output logic                 MIN_TICK
);

  tk_state_t   state;
  tk_state_t   state_next;

  logic        sec_inc;
  logic        sec_clr;
  logic        sec_wrap;
  logic        set_min_inc;
  logic        set_hour_inc;
  logic        run_active;
  logic        min_inc;
  logic        minlow_wrap;
  logic        minhigh_wrap;
  logic        hour_inc;
  hour_state_t hour_cur;
  hour_state_t hour_nxt;

  // Mode register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Mode decode: a mode change swallows any tick in the same cycle, and set
  // pulses only count once the SET state has actually been entered.
  always_comb begin
    state_next   = state;
    sec_inc      = 1'b0;
    sec_clr      = 1'b0;
    set_min_inc  = 1'b0;
    set_hour_inc = 1'b0;
    run_active   = 1'b0;
    case (state)
      ST_RUN: begin
        if (SET_MODE) begin
          state_next = ST_SET;
          sec_clr    = 1'b1;
        end else begin
          sec_inc    = SEC_TICK;
          run_active = 1'b1;
        end
      end
      ST_SET: begin
        sec_clr      = 1'b1;
        set_min_inc  = SET_MIN;
        set_hour_inc = SET_HOUR;
        if (!SET_MODE) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  assign min_inc  = sec_wrap | set_min_inc;
  assign hour_inc = (run_active & minhigh_wrap) | set_hour_inc;

  time_keeper_mod_counter #(
    .WIDTH (SEC_W),
    .MIN   (0),
    .MAX   (SECS_PER_MIN - 1)
  ) u_sec (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (sec_clr),
    .INC   (sec_inc),
    .Q     (SEC),
    .WRAP  (sec_wrap)
  );

  time_keeper_mod_counter #(
    .WIDTH (MINLOW_W),
    .MIN   (0),
    .MAX   (MINLOW_MAX)
  ) u_minlow (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (1'b0),
    .INC   (min_inc),
    .Q     (MINLOW),
    .WRAP  (minlow_wrap)
  );

  time_keeper_mod_counter #(
    .WIDTH (MINHIGH_W),
    .MIN   (0),
    .MAX   (MINHIGH_MAX)
  ) u_minhigh (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (1'b0),
    .INC   (minlow_wrap),
    .Q     (MINHIGH),
    .WRAP  (minhigh_wrap)
  );

  assign hour_cur = '{ampm: AMPM, hour: HOUR};
  assign hour_nxt = next_hour(hour_cur);

  // Hour and AM/PM register, reset to 12 AM.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      AMPM <= 1'b0;
      HOUR <= HOUR_W'(HOUR_MAX);
    end else if (hour_inc) begin
      AMPM <= hour_nxt.ampm;
      HOUR <= hour_nxt.hour;
    end
  end

  // One-cycle strobe whenever the minute fields advance.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MIN_TICK <= 1'b0;
    end else begin
      MIN_TICK <= min_inc;
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with a 4-tick minute.
module tb_time_keeper;

  logic       clk;
  logic       rst_n;
  logic       sec_tick;
  logic       set_mode;
  logic       set_hour;
  logic       set_min;
  logic       ampm;
  logic [3:0] hour;
  logic [2:0] minhigh;
  logic [3:0] minlow;
  logic [5:0] sec;
  logic       min_tick;

  int check_count = 0;
  int error_count = 0;

  time_keeper #(.SECS_PER_MIN(4)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .SEC_TICK (sec_tick),
    .SET_MODE (set_mode),
    .SET_HOUR (set_hour),
    .SET_MIN  (set_min),
    .AMPM     (ampm),
    .HOUR     (hour),
    .MINHIGH  (minhigh),
    .MINLOW   (minlow),
    .SEC      (sec),
    .MIN_TICK (min_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed != expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkTime(input string tag, input int e_ampm, input int e_hour,
                           input int e_mh, input int e_ml);
    checkOutput({tag, ".ampm"}, int'(ampm), e_ampm);
    checkOutput({tag, ".hour"}, int'(hour), e_hour);
    checkOutput({tag, ".minhigh"}, int'(minhigh), e_mh);
    checkOutput({tag, ".minlow"}, int'(minlow), e_ml);
  endtask

  // Drive one cycle of inputs, let one rising edge take them, then drop pulses.
  task automatic applyStimulus(input logic mode, input logic tick, input logic hr, input logic mn);
    set_mode = mode;
    sec_tick = tick;
    set_hour = hr;
    set_min  = mn;
    @(posedge clk);
    #1;
    sec_tick = 1'b0;
    set_hour = 1'b0;
    set_min  = 1'b0;
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    sec_tick = 1'b0;
    set_mode = 1'b0;
    set_hour = 1'b0;
    set_min  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Enter SET, pulse hour and minute the given number of times, stay in SET.
  task automatic presetTime(input int hour_pulses, input int min_pulses);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < hour_pulses; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < min_pulses; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    sec_tick = 1'b0;
    set_mode = 1'b0;
    set_hour = 1'b0;
    set_min  = 1'b0;

    // Scenario 1: reset values, then one minute of ticks.
    repeat (2) @(posedge clk);
    #1;
    checkTime("rst", 0, 12, 0, 0);
    checkOutput("rst.sec", int'(sec), 0);
    checkOutput("rst.min_tick", int'(min_tick), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    runTicks(3);
    checkOutput("s1.sec3", int'(sec), 3);
    checkOutput("s1.no_tick", int'(min_tick), 0);
    runTicks(1);
    checkTime("s1.1201", 0, 12, 0, 1);
    checkOutput("s1.sec_wrap", int'(sec), 0);
    checkOutput("s1.min_tick", int'(min_tick), 1);
    checkOutput("s1.alarm_same", int'({ampm, hour, minhigh, minlow}),
                int'({1'b0, 4'd12, 3'd0, 4'd1}));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s1.min_tick_end", int'(min_tick), 0);

    // Scenario 2: 11:59 AM rolls to 12:00 PM.
    doReset();
    presetTime(11, 59);
    checkTime("s2.preset", 0, 11, 5, 9);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(4);
    checkTime("s2.noon", 1, 12, 0, 0);

    // Scenario 3: 12:59 PM -> 1:00 PM and 11:59 PM -> 12:00 AM.
    doReset();
    presetTime(12, 59);
    checkTime("s3.preset_a", 1, 12, 5, 9);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(4);
    checkTime("s3.one_pm", 1, 1, 0, 0);
    doReset();
    presetTime(23, 59);
    checkTime("s3.preset_b", 1, 11, 5, 9);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(4);
    checkTime("s3.midnight", 0, 12, 0, 0);

    // Scenario 4: setting wraps minutes without hour carry; joint set pulses.
    doReset();
    presetTime(3, 59);
    checkTime("s4.preset", 0, 3, 5, 9);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkTime("s4.min_wrap", 0, 3, 0, 0);
    checkOutput("s4.min_tick", int'(min_tick), 1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkTime("s4.eleven", 0, 11, 0, 0);
    checkOutput("s4.hour_no_tick", int'(min_tick), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkTime("s4.both", 1, 12, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkTime("s4.ticks_ignored", 1, 12, 0, 1);
    checkOutput("s4.sec_held", int'(sec), 0);

    // Scenario 5: entering SET with a coincident tick and set pulses.
    doReset();
    runTicks(2);
    checkOutput("s5.sec2", int'(sec), 2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("s5.sec_cleared", int'(sec), 0);
    checkTime("s5.pulses_ignored", 0, 12, 0, 0);
    checkOutput("s5.no_min_tick", int'(min_tick), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("s5.sec_in_set", int'(sec), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(3);
    checkOutput("s5.sec_restart", int'(sec), 3);
    checkTime("s5.pre_min", 0, 12, 0, 0);
    runTicks(1);
    checkTime("s5.min_plus", 0, 12, 0, 1);

    // Scenario 6: asynchronous reset between clock edges at 7:42 PM.
    doReset();
    presetTime(19, 42);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(2);
    checkTime("s6.preset", 1, 7, 4, 2);
    checkOutput("s6.sec2", int'(sec), 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkTime("s6.async", 0, 12, 0, 0);
    checkOutput("s6.async_sec", int'(sec), 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
